// File: rtl/div_unit.sv
// div_unit - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Takes one request per handshake, grinds one quotient bit per clock and
// returns a single word (quotient or remainder, per the latched op). The
// hazard unit stalls the pipe on o_Busy while a divide is in flight.
//
// Ports:
//   i_CLK     rising-edge clock
//   i_RSTn    synchronous, active-low reset
//   i_Flush   abort any in-flight op; also drops a same-cycle request
//   i_Valid   request valid            o_Ready  unit can accept a request
//   i_Op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_A       dividend (rs1)           i_B      divisor (rs2)
//   o_Valid   result valid             i_Ready  consumer accepts result
//   o_Result  quotient or remainder    o_Busy   high in BUSY or DONE
//
// Optional feature (macro HAZE_DIV_EARLY_EXIT_EN): when |A| < |B| the result
// is known at accept (quotient 0, remainder A) and is returned after one
// cycle instead of WIDTH. Results are identical with or without it.

module div_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [1:0]       i_Op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, quo_q, bmag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_rem_q, neg_quo_q, neg_rem_q, special_q;

    // ---------------- accept-side operand conditioning ----------------
    logic               signed_op, a_neg, b_neg, b_zero, ovf, early, special, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;

    assign signed_op = ~i_Op[0];
    assign a_neg     = signed_op & i_A[WIDTH-1];
    assign b_neg     = signed_op & i_B[WIDTH-1];
    assign a_mag     = a_neg ? (~i_A + 1'b1) : i_A;
    assign b_mag     = b_neg ? (~i_B + 1'b1) : i_B;
    assign b_zero    = (i_B == '0);
    // Most-negative / -1 overflows the signed quotient; RV32M defines it.
    assign ovf       = signed_op && (i_A == {1'b1, {(WIDTH-1){1'b0}}}) && (i_B == '1);

`ifdef HAZE_DIV_EARLY_EXIT_EN
    assign early     = !b_zero && (a_mag < b_mag);
`else
    assign early     = 1'b0;
`endif

    // Special cases preload quo/rem with the final answer and skip the loop.
    assign special   = b_zero | ovf | early;
    assign accept    = (state_q == S_IDLE) && i_Valid && !i_Flush;

    // ---------------- one restoring step ----------------
    // rem_sh can exceed WIDTH bits (unsigned divisors near 2^WIDTH), so the
    // compare uses the full WIDTH+1 bits; when it fits, the true difference
    // is below |B| and the low WIDTH bits of the subtraction are exact.
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   diff, rem_nx, quo_nx, rem_fix, quo_fix;
    logic               fits, last;

    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign fits    = (rem_sh >= {1'b0, bmag_q});
    assign diff    = rem_sh[WIDTH-1:0] - bmag_q;
    assign rem_nx  = fits ? diff : rem_sh[WIDTH-1:0];
    assign quo_nx  = {quo_q[WIDTH-2:0], fits};
    assign quo_fix = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
    assign rem_fix = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_Ready = 1'b0;
        o_Busy  = 1'b0;
        o_Valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_Ready = 1'b1;
                if (i_Valid) state_d = S_BUSY;
            end
            S_BUSY: begin
                o_Busy = 1'b1;
                if (special_q || last) state_d = S_DONE;
            end
            S_DONE: begin
                o_Busy  = 1'b1;
                o_Valid = 1'b1;
                if (i_Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_Flush) state_d = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            rem_q     <= '0;
            quo_q     <= '0;
            bmag_q    <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            o_Result  <= '0;
        end else if (accept) begin
            is_rem_q  <= i_Op[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            bmag_q    <= b_mag;
            cnt_q     <= '0;
            special_q <= special;
            if (b_zero) begin
                quo_q <= '1;
                rem_q <= i_A;
            end else if (ovf) begin
                quo_q <= i_A;
                rem_q <= '0;
            end else if (early) begin
                quo_q <= '0;
                rem_q <= i_A;
            end else begin
                quo_q <= a_mag;
                rem_q <= '0;
            end
        end else if (state_q == S_BUSY && !i_Flush) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (special_q) begin
                // Preloaded answers are already signed correctly.
                o_Result <= is_rem_q ? rem_q : quo_q;
            end else begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                if (last) o_Result <= is_rem_q ? rem_fix : quo_fix;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int W = 32;
`ifdef HAZE_DIV_EARLY_EXIT_EN
    localparam int EE_LAT = 1;
`else
    localparam int EE_LAT = W;
`endif

    logic          i_CLK = 1'b0, i_RSTn = 1'b0, i_Flush = 1'b0;
    logic          i_Valid = 1'b0, i_Ready = 1'b0;
    logic [1:0]    i_Op = 2'b00;
    logic [W-1:0]  i_A = '0, i_B = '0;
    logic          o_Ready, o_Valid, o_Busy;
    logic [W-1:0]  o_Result;

    div_unit #(.WIDTH(W)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_Flush(i_Flush),
        .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Op(i_Op),
        .i_A(i_A), .i_B(i_B), .o_Valid(o_Valid), .i_Ready(i_Ready),
        .o_Result(o_Result), .o_Busy(o_Busy)
    );

    always #5 i_CLK = ~i_CLK;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        string       name;
    } vec_t;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

    // Present one request, scramble inputs after accept, measure latency,
    // check result, then retire it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string name);
        int n;
        i_Op = op; i_A = a; i_B = b; i_Valid = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0; i_A = ~a; i_B = b ^ 32'h5A5A_1234; i_Op = ~op;
        chk({name, " busy"}, {30'b0, o_Busy, o_Ready}, 32'd2);
        n = 0;
        while (!o_Valid && n < 100) begin
            @(posedge i_CLK); #1;
            n++;
        end
        chk({name, " lat"}, 32'(n), 32'(lat));
        chk({name, " res"}, o_Result, exp);
        i_Ready = 1'b1;
        @(posedge i_CLK); #1;
        i_Ready = 1'b0;
        chk({name, " ret"}, {30'b0, o_Valid, o_Ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic seen;

        vecs.push_back('{DIVU, 32'd100,        32'd7,          32'd14,         W,      "divu 100/7"});
        vecs.push_back('{REMU, 32'd100,        32'd7,          32'd2,          W,      "remu 100%7"});
        vecs.push_back('{DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  W,      "div -100/7"});
        vecs.push_back('{REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  W,      "rem -100%7"});
        vecs.push_back('{REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          W,      "rem 100%-7"});
        vecs.push_back('{DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         W,      "div -100/-7"});
        vecs.push_back('{REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  W,      "rem -100%-7"});
        vecs.push_back('{DIV,  32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFFE,  W,      "div 7/-3"});
        vecs.push_back('{REM,  32'd7,          32'hFFFF_FFFD,  32'd1,          W,      "rem 7%-3"});
        vecs.push_back('{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  W,      "div min/2"});
        vecs.push_back('{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  W,      "divu max/1"});
        vecs.push_back('{REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          W,      "remu max%16"});
        vecs.push_back('{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,      "div ovf"});
        vecs.push_back('{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,      "rem ovf"});
        vecs.push_back('{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,      "divu 5/0"});
        vecs.push_back('{REMU, 32'd5,          32'd0,          32'd5,          1,      "remu 5%0"});
        vecs.push_back('{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,      "div 5/0"});
        vecs.push_back('{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,      "rem -5%0"});
        vecs.push_back('{DIVU, 32'd3,          32'd10,         32'd0,          EE_LAT, "divu 3/10"});
        vecs.push_back('{REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EE_LAT, "rem -3%10"});
        vecs.push_back('{DIV,  32'd0,          32'd5,          32'd0,          EE_LAT, "div 0/5"});
        vecs.push_back('{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          EE_LAT, "divu min/max"});

        // Reset state
        repeat (2) @(posedge i_CLK);
        #1 i_RSTn = 1'b1;
        chk("reset flags", {29'b0, o_Ready, o_Valid, o_Busy}, 32'd4);
        chk("reset result", o_Result, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name);

        // Hold result in DONE while consumer stalls
        i_Op = DIVU; i_A = 32'd100; i_B = 32'd7; i_Valid = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        repeat (W) @(posedge i_CLK);
        #1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold res c%0d", c), o_Result, 32'd14);
            chk($sformatf("hold flags c%0d", c), {29'b0, o_Valid, o_Ready, o_Busy}, 32'd5);
            @(posedge i_CLK); #1;
        end
        i_Ready = 1'b1;
        @(posedge i_CLK); #1;
        i_Ready = 1'b0;
        chk("hold release", {29'b0, o_Valid, o_Ready, o_Busy}, 32'd2);

        // Flush at iteration 15; a same-cycle request must be dropped
        i_Op = DIVU; i_A = 32'hFFFF_FFFF; i_B = 32'd3; i_Valid = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        repeat (14) @(posedge i_CLK);
        #1;
        i_Flush = 1'b1; i_Valid = 1'b1; i_A = 32'd8; i_B = 32'd2;
        @(posedge i_CLK); #1;
        i_Flush = 1'b0; i_Valid = 1'b0;
        chk("flush idle", {29'b0, o_Valid, o_Ready, o_Busy}, 32'd2);
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_CLK); #1;
            if (o_Valid || o_Busy) seen = 1'b1;
        end
        chk("flush quiet", {31'b0, seen}, 32'd0);
        run_op(DIVU, 32'd9, 32'd3, 32'd3, W, "divu 9/3 post-flush");

        // Reset mid-operation
        i_Op = DIV; i_A = 32'hFFFF_FF9C; i_B = 32'd7; i_Valid = 1'b1;
        @(posedge i_CLK); #1;
        i_Valid = 1'b0;
        repeat (5) @(posedge i_CLK);
        #1 i_RSTn = 1'b0;
        @(posedge i_CLK); #1;
        i_RSTn = 1'b1;
        chk("midrst flags", {29'b0, o_Ready, o_Valid, o_Busy}, 32'd4);
        chk("midrst result", o_Result, 32'd0);
        run_op(REMU, 32'd100, 32'd7, 32'd2, W, "remu post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage beside the set-less comparator and adder.
- Takes operands from the ID/EX operand path and returns one word to the EX/MEM result mux.
- Uses valid/ready on both sides so the hazard unit can stall the pipe while a divide is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and at least 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not to be overridden).

Ports:
- i_CLK  in  1  rising-edge clock
- i_RSTn  in  1  synchronous, active-low reset
- i_Flush  in  1  abort any in-flight op (pipeline flush)
- i_Valid  in  1  request valid
- o_Ready  out  1  unit can accept a request
- i_Op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_A  in  WIDTH  dividend (rs1)
- i_B  in  WIDTH  divisor (rs2)
- o_Valid  out  1  result valid
- i_Ready  in  1  consumer accepts result
- o_Result  out  WIDTH  quotient or remainder per latched op
- o_Busy  out  1  high in BUSY or DONE (drives hazard stall)

Behaviour:
- Reset (i_RSTn=0 at an edge): state IDLE, o_Valid=0, o_Result=0, o_Busy=0, counter=0, all operand registers 0. o_Ready=1 in the first cycle after reset.
- States:
  - IDLE: o_Ready=1.
  - BUSY: o_Ready=0, o_Busy=1.
  - DONE: o_Ready=0, o_Valid=1, o_Busy=1.
- IDLE->BUSY on i_Valid&&o_Ready at edge k:
  - latch op and sign flags (sign of A for signed ops; sign of A xor sign of B for signed quotient);
  - latch |A|, |B| (raw values for unsigned ops);
  - clear remainder accumulator; counter=0.
- Special cases at accept go IDLE->DONE directly, with o_Valid after edge k+1:
  - B==0: quotient = all ones; remainder = A.
  - Signed op, A==0x8000_0000 and B==all ones: quotient = A; remainder = 0.
- BUSY: one restoring step per edge:
  - shift {rem,quo} left by 1;
  - trial subtract rem-|B| (WIDTH+1 bits);
  - if non-negative, keep the difference and set quo LSB to 1.
  - After the WIDTH-th step (edge k+WIDTH), apply the sign fix: negate quotient if the quotient sign flag is set; negate remainder if A was negative for a signed op. Register o_Result and go DONE.
  - Latency from accept to o_Valid is exactly WIDTH cycles (32 by default).
- DONE: o_Result and o_Valid are held stable until i_Ready=1, then go to IDLE at that edge. There is no accept in the same cycle, so the next request can be accepted one cycle later.
- i_Flush=1 at any edge goes to IDLE with o_Valid=0 and overrides every other condition. A request presented in the same cycle as i_Flush is dropped.
- i_RSTn=0 mid-operation behaves like reset: state IDLE, all outputs to their reset values.
- Inputs are sampled only at accept; later changes to i_A, i_B or i_Op have no effect.
- Remainder sign always follows the dividend; |remainder| < |divisor|.

Optional Feature:
- Macro: HAZE_DIV_EARLY_EXIT_EN.
- Defined: at accept, if the magnitude of A is less than the magnitude of B (and B!=0), go directly to DONE the next edge with quotient=0 and remainder=A (original signed value). 1-cycle latency.
- Undefined: such operands take the full WIDTH-cycle iteration. The result is identical either way; only latency differs.

Test Plan:
- DIVU A=100, B=7 -> o_Valid exactly 32 cycles after accept, o_Result=14; REMU with the same operands -> 2.
- DIV A=0xFFFF_FF9C (-100), B=7 -> 0xFFFF_FFF2 (-14); REM -> 0xFFFF_FFFE (-2); REM A=100, B=0xFFFF_FFF9 (-7) -> 2.
- DIV A=0x8000_0000, B=0xFFFF_FFFF -> 0x8000_0000 after 1 cycle; REM -> 0; DIVU A=5, B=0 -> 0xFFFF_FFFF after 1 cycle; REMU -> 5.
- Hold i_Ready=0 for 10 cycles in DONE -> o_Result stable and o_Ready=0 throughout; on the i_Ready=1 edge go IDLE and o_Ready=1 the next cycle.
- Assert i_Flush at iteration 15 of DIVU 0xFFFF_FFFF/3 -> IDLE next edge, o_Valid never rises. A new DIVU 9/3 accepted afterwards -> 3 with full latency.
- DIVU A=3, B=10 -> o_Result=0: 1-cycle latency with HAZE_DIV_EARLY_EXIT_EN defined, 32-cycle latency without it.
